// File: rtl/alu_div_unit.sv
// Iterative radix-2 restoring divide/remainder unit (DIV, DIVU, REM, REMU), one quotient bit per cycle.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip the iteration phase.
module alu_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [4:0] AluDiv  = 5'b01100;
    localparam logic [4:0] AluDivu = 5'b01101;
    localparam logic [4:0] AluRem  = 5'b01010;
    localparam logic [4:0] AluRemu = 5'b01011;

    localparam logic [WIDTH-1:0] One    = WIDTH'(1);
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] a_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_rem_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             div_zero_q;
    logic             ovf_q;

    logic             op_valid;
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             start_dz;
    logic             start_ovf;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] res_fix;

    always_comb begin
        op_valid  = (op == AluDiv) || (op == AluDivu) || (op == AluRem) || (op == AluRemu);
        op_signed = (op == AluDiv) || (op == AluRem);
        a_neg     = op_signed & a[WIDTH-1];
        b_neg     = op_signed & b[WIDTH-1];
        a_mag     = a_neg ? (~a + One) : a;
        b_mag     = b_neg ? (~b + One) : b;
        start_dz  = (b == '0);
        start_ovf = op_signed && (a == MinNeg) && (b == '1);
    end

    // Restoring step: the partial remainder stays below the divisor, so WIDTH+1 bits suffice.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
    end

    always_comb begin
        quo_fix = neg_quo_q ? (~quo_q + One) : quo_q;
        rem_fix = neg_rem_q ? (~rem_q + One) : rem_q;
        if (div_zero_q) begin
            quo_fix = '1;
            rem_fix = a_q;
        end else if (ovf_q) begin
            quo_fix = MinNeg;
            rem_fix = '0;
        end
        res_fix = is_rem_q ? rem_fix : quo_fix;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            a_q        <= '0;
            cnt_q      <= '0;
            is_rem_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
        end else if (flush) begin
            // Abort wins over everything; result keeps its last value.
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start && op_valid) begin
                        is_rem_q   <= (op == AluRem) || (op == AluRemu);
                        neg_quo_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        div_zero_q <= start_dz;
                        ovf_q      <= start_ovf;
                        a_q        <= a;
                        quo_q      <= a_mag;
                        dvs_q      <= b_mag;
                        rem_q      <= '0;
                        cnt_q      <= CNT_W'(WIDTH);
                        busy       <= 1'b1;
`ifdef DIV_FAST_SPECIAL_EN
                        state_q    <= (start_dz || start_ovf) ? StFix : StCalc;
`else
                        state_q    <= StCalc;
`endif
                    end
                end
                StCalc: begin
                    if (!diff[WIDTH]) begin
                        rem_q <= diff[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= shifted[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    result  <= res_fix;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div_unit.sv
// Directed self-checking bench for alu_div_unit: arithmetic, special cases, latency, flush and reset.
module tb_alu_div_unit;

    localparam logic [4:0] ALU_DIV  = 5'b01100;
    localparam logic [4:0] ALU_DIVU = 5'b01101;
    localparam logic [4:0] ALU_REM  = 5'b01010;
    localparam logic [4:0] ALU_REMU = 5'b01011;
    localparam logic [4:0] ALU_ADD  = 5'b00000;

    localparam int NORM_LAT = 34;
`ifdef DIV_FAST_SPECIAL_EN
    localparam int SPEC_LAT = 2;
`else
    localparam int SPEC_LAT = 34;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp;
    int n_err;

    alu_div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one op; returns the cycle (relative to the start cycle) in which done was seen,
    // or 0 if it never came. Operands are scrambled right after acceptance.
    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        lat = 0;
        nbusy = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0; op = ALU_ADD; a = 32'hDEADBEEF; b = 32'h12345678;
            end
            if (busy) nbusy++;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 0", result); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_divu();
        int lat, nb;
        run_op(ALU_DIVU, 32'd100, 32'd7, lat, nb);
        n_cmp++; if (result !== 32'd14) begin n_err++; $display("FAIL divu_100_7 got %h want %h", result, 32'd14); end
        n_cmp++; if (lat !== NORM_LAT) begin n_err++; $display("FAIL divu_latency got %0d want %0d", lat, NORM_LAT); end
        n_cmp++; if (nb !== 33) begin n_err++; $display("FAIL divu_busy_cycles got %0d want 33", nb); end
        run_op(ALU_DIVU, 32'hFFFFFFFF, 32'd2, lat, nb);
        n_cmp++; if (result !== 32'h7FFFFFFF) begin n_err++; $display("FAIL divu_max_2 got %h want 7fffffff", result); end
    endtask

    task automatic test_signed();
        int lat, nb;
        run_op(ALU_REM, 32'hFFFFFF9C, 32'd7, lat, nb);
        n_cmp++; if (result !== 32'hFFFFFFFE) begin n_err++; $display("FAIL rem_m100_7 got %h want fffffffe", result); end
        run_op(ALU_DIV, 32'hFFFFFF9C, 32'd7, lat, nb);
        n_cmp++; if (result !== 32'hFFFFFFF2) begin n_err++; $display("FAIL div_m100_7 got %h want fffffff2", result); end
        run_op(ALU_DIV, 32'd7, 32'hFFFFFFFE, lat, nb);
        n_cmp++; if (result !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_7_m2 got %h want fffffffd", result); end
        run_op(ALU_REM, 32'd7, 32'hFFFFFFFE, lat, nb);
        n_cmp++; if (result !== 32'd1) begin n_err++; $display("FAIL rem_7_m2 got %h want 1", result); end
    endtask

    task automatic test_overflow();
        int lat, nb;
        run_op(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, lat, nb);
        n_cmp++; if (result !== 32'h80000000) begin n_err++; $display("FAIL div_ovf got %h want 80000000", result); end
        n_cmp++; if (lat !== SPEC_LAT) begin n_err++; $display("FAIL div_ovf_latency got %0d want %0d", lat, SPEC_LAT); end
        run_op(ALU_REM, 32'h80000000, 32'hFFFFFFFF, lat, nb);
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL rem_ovf got %h want 0", result); end
    endtask

    task automatic test_div_zero();
        int lat, nb;
        run_op(ALU_DIVU, 32'd5, 32'd0, lat, nb);
        n_cmp++; if (result !== 32'hFFFFFFFF) begin n_err++; $display("FAIL divu_by0 got %h want ffffffff", result); end
        n_cmp++; if (lat !== SPEC_LAT) begin n_err++; $display("FAIL divu_by0_latency got %0d want %0d", lat, SPEC_LAT); end
        run_op(ALU_REMU, 32'd5, 32'd0, lat, nb);
        n_cmp++; if (result !== 32'd5) begin n_err++; $display("FAIL remu_by0 got %h want 5", result); end
        run_op(ALU_DIV, 32'hFFFFFFFB, 32'd0, lat, nb);
        n_cmp++; if (result !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_m5_by0 got %h want ffffffff", result); end
        run_op(ALU_REM, 32'hFFFFFFFB, 32'd0, lat, nb);
        n_cmp++; if (result !== 32'hFFFFFFFB) begin n_err++; $display("FAIL rem_m5_by0 got %h want fffffffb", result); end
    endtask

    task automatic test_flush();
        int lat, nb, seen;
        run_op(ALU_DIVU, 32'd21, 32'd4, lat, nb);
        n_cmp++; if (result !== 32'd5) begin n_err++; $display("FAIL divu_21_4 got %h want 5", result); end
        @(negedge clk);
        start = 1'b1; op = ALU_DIVU; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL flush_done got %b want 0", done); end
        n_cmp++; if (result !== 32'd5) begin n_err++; $display("FAIL flush_result got %h want 5", result); end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL flush_quiet got %0d active cycles want 0", seen); end
        run_op(ALU_DIVU, 32'd9, 32'd3, lat, nb);
        n_cmp++; if (result !== 32'd3) begin n_err++; $display("FAIL post_flush_divu got %h want 3", result); end
        n_cmp++; if (lat !== NORM_LAT) begin n_err++; $display("FAIL post_flush_latency got %0d want %0d", lat, NORM_LAT); end
    endtask

    task automatic test_back_to_back();
        int lat, nb;
        run_op(ALU_REMU, 32'd10, 32'd4, lat, nb);
        n_cmp++; if (result !== 32'd2) begin n_err++; $display("FAIL b2b_first got %h want 2", result); end
        run_op(ALU_DIVU, 32'd1000, 32'd3, lat, nb);
        n_cmp++; if (result !== 32'd333) begin n_err++; $display("FAIL b2b_second got %h want %h", result, 32'd333); end
        n_cmp++; if (lat !== NORM_LAT) begin n_err++; $display("FAIL b2b_latency got %0d want %0d", lat, NORM_LAT); end
    endtask

    task automatic test_invalid_op();
        int seen;
        seen = 0;
        @(negedge clk);
        start = 1'b1; op = ALU_ADD; a = 32'd50; b = 32'd5;
        repeat (40) begin
            @(negedge clk);
            if (busy || done) seen++;
        end
        start = 1'b0;
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL invalid_op got %0d active cycles want 0", seen); end
        n_cmp++; if (result !== 32'd333) begin n_err++; $display("FAIL invalid_op_result got %h want %h", result, 32'd333); end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        start = 1'b1; op = ALU_DIVU; a = 32'd77; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_mid_done got %b want 0", done); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL rst_mid_result got %h want 0", result); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", seen); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_divu();
        test_signed();
        test_overflow();
        test_div_zero();
        test_flush();
        test_back_to_back();
        test_invalid_op();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
